// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS core: sequences a shared-memory
// datapath through IF/ID/EX/MEM/WB (plus BR/JMP), handshakes with a
// variable-latency memory, guards memory waits with a watchdog and parks
// in a sticky ERR state on illegal instructions or memory timeouts.
//
// Ports
//   clk, rst_n           clock (rising) / async active-low reset
//   opcode, funct        IR fields, stable from the cycle after ir_wr
//   zero, ovf            ALU flags (combinational)
//   mem_ready            completion of the current mem_req
//   mem_req, memwrite    memory request / store strobe
//   ir_wr, pc_wr         IR load / PC write enables
//   npc_sel, j_sel, jr_sel, jal_sel   PC source / link selects
//   regwr, memtoreg, rd_dst, slt_sel  writeback controls
//   alusrc, aluop, extop ALU operand / operation / immediate extension
//   instr_done           one-cycle retire pulse
//   instr_count          retired-instruction count (wraps)
//   err_code             00 none, 01 illegal instr, 10 memory timeout
//   state                current FSM state for debug
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             ovf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             npc_sel,
  output logic             j_sel,
  output logic             jr_sel,
  output logic             jal_sel,
  output logic             regwr,
  output logic             memtoreg,
  output logic             rd_dst,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic [1:0]       extop,
  output logic             slt_sel,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       err_code,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IF  = 3'd0, S_ID  = 3'd1, S_EX  = 3'd2, S_MEM = 3'd3,
                         S_WB  = 3'd4, S_BR  = 3'd5, S_JMP = 3'd6, S_ERR = 3'd7;

  // Wait counter only ever needs to hold 0..TIMEOUT-1.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Instruction decode
  logic is_r;
  logic d_addu, d_subu, d_slt, d_jr, d_ori, d_lui, d_addi, d_addiu;
  logic d_lw, d_sw, d_beq, d_j, d_jal, d_ex, d_jmp;

  assign is_r    = (opcode == 6'h00);
  assign d_addu  = is_r && (funct == 6'h21);
  assign d_subu  = is_r && (funct == 6'h23);
  assign d_slt   = is_r && (funct == 6'h2a);
  assign d_jr    = is_r && (funct == 6'h08);
  assign d_ori   = (opcode == 6'h0d);
  assign d_lui   = (opcode == 6'h0f);
  assign d_addi  = (opcode == 6'h08);
  assign d_addiu = (opcode == 6'h09);
  assign d_lw    = (opcode == 6'h23);
  assign d_sw    = (opcode == 6'h2b);
  assign d_beq   = (opcode == 6'h04);
  assign d_j     = (opcode == 6'h02);
  assign d_jal   = (opcode == 6'h03);
  assign d_ex    = d_addu | d_subu | d_slt | d_ori | d_lui | d_addi | d_addiu | d_lw | d_sw;
  assign d_jmp   = d_j | d_jal | d_jr;

  logic [2:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wd_trip;

  // Threshold cycle: a ready response here still wins over the timeout.
  assign wd_trip = (TIMEOUT != 0) && !mem_ready && (wait_q == WW'(TIMEOUT - 1));

  // State register and datapath-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      wait_q  <= '0;
      err_q   <= 2'b00;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (state_q == S_EX) ovf_q <= ovf;
      if (instr_done)      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IF: begin
        if (mem_ready)    state_d = S_ID;
        else if (wd_trip) begin state_d = S_ERR; err_d = 2'b10; end
      end
      S_ID: begin
        if (d_ex)        state_d = S_EX;
        else if (d_beq)  state_d = S_BR;
        else if (d_jmp)  state_d = S_JMP;
        else begin state_d = S_ERR; err_d = 2'b01; end
      end
      S_EX:  state_d = (d_lw || d_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)    state_d = d_lw ? S_WB : S_IF;
        else if (wd_trip) begin state_d = S_ERR; err_d = 2'b10; end
      end
      S_WB, S_BR, S_JMP: state_d = S_IF;
      S_ERR: state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Counter runs only while parked in IF/MEM; any state change clears it,
  // so it is zero on every entry to IF or MEM.
  always_comb begin
    wait_d = '0;
    if ((TIMEOUT != 0) && (state_q == S_IF || state_q == S_MEM) && (state_d == state_q))
      wait_d = wait_q + WW'(1);
  end

  // Output decode
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    npc_sel    = 1'b0;
    j_sel      = 1'b0;
    jr_sel     = 1'b0;
    jal_sel    = 1'b0;
    regwr      = 1'b0;
    memtoreg   = 1'b0;
    rd_dst     = 1'b0;
    alusrc     = 1'b0;
    aluop      = 2'b00;
    extop      = 2'b00;
    slt_sel    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        // Keep the IR/PC strobes quiet while reset is held.
        ir_wr   = mem_ready & rst_n;
        pc_wr   = mem_ready & rst_n;
      end
      S_EX: begin
        if (d_subu || d_slt) aluop = 2'b01;
        else if (d_ori)      aluop = 2'b10;
        alusrc = d_ori | d_lui | d_addi | d_addiu | d_lw | d_sw;
        if (d_lui)                               extop = 2'b10;
        else if (d_addi || d_addiu || d_lw || d_sw) extop = 2'b01;
      end
      S_MEM: begin
        mem_req    = 1'b1;
        memwrite   = d_sw;
        instr_done = d_sw & mem_ready;
      end
      S_WB: begin
        regwr      = !(d_addi && ovf_q);
        memtoreg   = d_lw;
        rd_dst     = d_addu | d_subu | d_slt;
        slt_sel    = d_slt;
        instr_done = 1'b1;
      end
      S_BR: begin
        aluop      = 2'b01;
        pc_wr      = zero;
        npc_sel    = zero;
        instr_done = 1'b1;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        j_sel      = d_j | d_jal;
        jal_sel    = d_jal;
        regwr      = d_jal;
        jr_sel     = d_jr;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign err_code    = err_q;
  assign instr_count = cnt_q;

endmodule
